// File: rtl/echo_ram_sched_pkg.sv
// Shared definitions for the echo delay-line RAM sequencer.
//   ECHO_AW / ECHO_DW : default RAM address width and sample width
//   state_t           : sequencer states, one cycle per non-IDLE state
package echo_ram_sched_pkg;

  localparam int ECHO_AW = 13;
  localparam int ECHO_DW = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    RD1   = 3'd2,
    RD2   = 3'd3,
    CAP   = 3'd4
  } state_t;

endpackage

// File: rtl/echo_ram_sched_if.sv
// Delay-line RAM port bundle: one write port (a) and one registered read port (b).
//   we_a  : write enable          adr_a : write address     dat_a : write data
//   adr_b : read address          dat_b : read data, valid the cycle after adr_b is registered
// master = sequencer side, slave = RAM side.
interface echo_ram_sched_if
  import echo_ram_sched_pkg::*;
#(
  parameter int AW = ECHO_AW,
  parameter int DW = ECHO_DW
);

  logic          we_a;
  logic [AW-1:0] adr_a;
  logic [DW-1:0] dat_a;
  logic [AW-1:0] adr_b;
  logic [DW-1:0] dat_b;

  modport master (
    output we_a,
    output adr_a,
    output dat_a,
    output adr_b,
    input  dat_b
  );

  modport slave (
    input  we_a,
    input  adr_a,
    input  dat_a,
    input  adr_b,
    output dat_b
  );

endinterface

// File: rtl/echo_ram_sched_tap_addr.sv
// Combinational tap address generator, one instance per delay tap.
//   wr_ptr_w  : address of the sample being written for this sequence
//   par_delay : requested tap delay in samples (full 32 bits)
//   fill      : number of samples written before the current one (saturating)
//   d         : delay clamped to DEPTH-1
//   adr       : wr_ptr_w - d, wrapping modulo DEPTH
//   mask      : tap reaches further back than anything written yet; output must read as 0
module echo_tap_addr
  import echo_ram_sched_pkg::*;
#(
  parameter int AW = ECHO_AW
) (
  input  logic [AW-1:0] wr_ptr_w,
  input  logic [31:0]   par_delay,
  input  logic [AW-1:0] fill,
  output logic [AW-1:0] d,
  output logic [AW-1:0] adr,
  output logic          mask
);

  localparam logic [31:0] D_MAX = 32'((2 ** AW) - 1);

  always_comb begin
    // Clamp on the full 32 bits so huge requests saturate instead of aliasing.
    d    = (par_delay > D_MAX) ? {AW{1'b1}} : par_delay[AW-1:0];
    adr  = wr_ptr_w - d;
    mask = (d > fill);
  end

endmodule

// File: rtl/echo_ram_sched.sv
// Echo delay-line RAM sequencer. For each accepted ADC sample it writes the
// sample into the circular delay line, then reads two delayed taps through the
// registered read port and presents current/tap1/tap2 together.
//
// Ports
//   clk, reset        : single clock, synchronous active-high reset
//   enable            : gates acceptance of new samples only
//   data_rdy/data_adc : ADC sample strobe (level) and sample
//   par_delay1/2      : tap delays in samples, latched on acceptance
//   ram               : delay-line RAM port bundle (master side)
//   realt/delay1/2    : current sample and tap samples, held between pulses
//   out_valid         : one-cycle pulse, outputs updated this cycle
//   busy              : high in every state except IDLE
//   overrun           : one-cycle pulse, a sample edge was dropped while busy
//   fsm_state         : current sequencer state (debug)
//   tap_d1/tap_d2     : clamped delays in use for the current sequence (debug)
//
// Handshake: a sample is offered by a rising edge of data_rdy (data_adc stable
// while data_rdy is high). It is taken only when enable is high and the
// sequencer is IDLE; an edge with enable high while busy is dropped and flagged
// on overrun. Results appear exactly 4 cycles after acceptance with a
// one-cycle out_valid pulse; there is no back-pressure on the result side.
module echo_ram_sched
  import echo_ram_sched_pkg::*;
#(
  parameter int AW = ECHO_AW,
  parameter int DW = ECHO_DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              data_rdy,
  input  logic [DW-1:0]     data_adc,
  input  logic [31:0]       par_delay1,
  input  logic [31:0]       par_delay2,
  echo_ram_sched_if.master  ram,
  output logic [DW-1:0]     realt,
  output logic [DW-1:0]     delay1,
  output logic [DW-1:0]     delay2,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun,
  output state_t            fsm_state,
  output logic [AW-1:0]     tap_d1,
  output logic [AW-1:0]     tap_d2
);

  state_t        state;
  state_t        state_next;

  logic          prev_rdy;
  logic          rise;
  logic          accept;

  logic [DW-1:0] sample;
  logic [31:0]   pd1;
  logic [31:0]   pd2;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] fill;
  logic [AW-1:0] adr_b_q;
  logic          mask1;
  logic          mask2;
  logic [DW-1:0] tap1;

  logic [AW-1:0] t1_adr;
  logic [AW-1:0] t2_adr;
  logic          t1_mask;
  logic          t2_mask;

  assign rise   = data_rdy & ~prev_rdy;
  assign accept = rise & enable & (state == IDLE);

  // wr_ptr and fill only advance when leaving RD1, so during WRITE and RD1
  // they still describe the sample being written and the history before it.
  echo_tap_addr #(.AW(AW)) u_tap1 (
    .wr_ptr_w  (wr_ptr),
    .par_delay (pd1),
    .fill      (fill),
    .d         (tap_d1),
    .adr       (t1_adr),
    .mask      (t1_mask)
  );

  echo_tap_addr #(.AW(AW)) u_tap2 (
    .wr_ptr_w  (wr_ptr),
    .par_delay (pd2),
    .fill      (fill),
    .d         (tap_d2),
    .adr       (t2_adr),
    .mask      (t2_mask)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = WRITE;
      WRITE:   state_next = RD1;
      RD1:     state_next = RD2;
      RD2:     state_next = CAP;
      CAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ram.we_a  = (state == WRITE);
    ram.adr_a = wr_ptr;
    ram.dat_a = sample;
    ram.adr_b = adr_b_q;
    busy      = (state != IDLE);
    fsm_state = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_rdy  <= 1'b0;
      sample    <= '0;
      pd1       <= '0;
      pd2       <= '0;
      wr_ptr    <= '0;
      fill      <= '0;
      adr_b_q   <= '0;
      mask1     <= 1'b0;
      mask2     <= 1'b0;
      tap1      <= '0;
      realt     <= '0;
      delay1    <= '0;
      delay2    <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      prev_rdy  <= data_rdy;
      out_valid <= 1'b0;
      overrun   <= rise & enable & (state != IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            sample <= data_adc;
            pd1    <= par_delay1;
            pd2    <= par_delay2;
          end
        end
        WRITE: begin
          // Tap-1 address goes out for RD1; both masks are frozen against the
          // pre-write fill so later fill updates cannot affect this sequence.
          adr_b_q <= t1_adr;
          mask1   <= t1_mask;
          mask2   <= t2_mask;
        end
        RD1: begin
          adr_b_q <= t2_adr;
          wr_ptr  <= wr_ptr + 1'b1;
          if (fill != {AW{1'b1}}) begin
            fill <= fill + 1'b1;
          end
        end
        RD2: begin
          tap1 <= mask1 ? '0 : ram.dat_b;
        end
        CAP: begin
          realt     <= sample;
          delay1    <= tap1;
          delay2    <= mask2 ? '0 : ram.dat_b;
          out_valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_echo_ram_sched.sv
// Testbench for echo_ram_sched: a RAM model on the slave side, a sample-history
// reference model, an expected-result queue and an independent output monitor.
module tb_echo_ram_sched;
  import echo_ram_sched_pkg::*;

  localparam int AW    = ECHO_AW;
  localparam int DW    = ECHO_DW;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          data_rdy = 1'b0;
  logic [DW-1:0] data_adc = '0;
  logic [31:0]   par_delay1 = '0;
  logic [31:0]   par_delay2 = '0;
  logic [DW-1:0] realt;
  logic [DW-1:0] delay1;
  logic [DW-1:0] delay2;
  logic          out_valid;
  logic          busy;
  logic          overrun;
  state_t        fsm_state;
  logic [AW-1:0] tap_d1;
  logic [AW-1:0] tap_d2;

  always #5 clk = ~clk;

  echo_ram_sched_if #(.AW(AW), .DW(DW)) ram_bus ();

  echo_ram_sched #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .data_rdy   (data_rdy),
    .data_adc   (data_adc),
    .par_delay1 (par_delay1),
    .par_delay2 (par_delay2),
    .ram        (ram_bus),
    .realt      (realt),
    .delay1     (delay1),
    .delay2     (delay2),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun),
    .fsm_state  (fsm_state),
    .tap_d1     (tap_d1),
    .tap_d2     (tap_d2)
  );

  // Delay-line RAM: synchronous write, registered read.
  logic [DW-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    ram_bus.dat_b = '0;
  end
  always @(posedge clk) begin
    if (ram_bus.we_a) mem[ram_bus.adr_a] <= ram_bus.dat_a;
    ram_bus.dat_b <= mem[ram_bus.adr_b];
  end

  // ---------------- scoreboard state ----------------
  int              checks = 0;
  int              errors = 0;
  logic [3*DW-1:0] exp_q[$];
  logic [DW-1:0]   hist[$];          // samples written since the last reset
  logic [3*DW-1:0] last = '0;        // outputs expected to hold between pulses
  int              exp_writes = 0;
  int              wr_seen = 0;
  int              exp_ovr = 0;
  int              ovr_seen = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int clampd(input logic [31:0] p);
    return (p > 32'(DEPTH - 1)) ? DEPTH - 1 : int'(p);
  endfunction

  // An accepted sample: its taps are the samples d back in the written history,
  // or 0 when fewer than d samples were written before it.
  task automatic model_accept(input logic [DW-1:0] x, input logic [31:0] p1,
                              input logic [31:0] p2, output int wa,
                              output int d1, output int d2);
    int fb;
    int n;
    logic [DW-1:0] t1;
    logic [DW-1:0] t2;
    d1 = clampd(p1);
    d2 = clampd(p2);
    fb = (hist.size() > DEPTH - 1) ? DEPTH - 1 : hist.size();
    hist.push_back(x);
    n  = hist.size() - 1;
    t1 = (d1 > fb) ? '0 : hist[n - d1];
    t2 = (d2 > fb) ? '0 : hist[n - d2];
    wa = n % DEPTH;
    exp_q.push_back({x, t1, t2});
    exp_writes++;
  endtask

  // ---------------- monitor ----------------
  always begin
    @(negedge clk);
    #1;
    if (ram_bus.we_a) wr_seen++;
    if (overrun) ovr_seen++;
    if (!reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'(0));
        end else begin
          logic [3*DW-1:0] e;
          e = exp_q.pop_front();
          check("outputs", 32'({realt, delay1, delay2}), 32'(e));
          last = e;
        end
      end else begin
        check("hold", 32'({realt, delay1, delay2}), 32'(last));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    hist.delete();
    last = '0;
    repeat (2) @(negedge clk);
    check("rst_outputs", 32'({realt, delay1, delay2}), 32'(0));
    check("rst_flags", 32'({out_valid, busy, overrun}), 32'(0));
    check("rst_state", 32'(fsm_state), 32'(IDLE));
    check("rst_ram_a", 32'({ram_bus.we_a, ram_bus.adr_a, ram_bus.dat_a}), 32'(0));
    check("rst_adr_b", 32'(ram_bus.adr_b), 32'(0));
    reset = 1'b0;
  endtask

  // Offer one sample when the sequencer is idle and follow it through.
  task automatic send(input logic [DW-1:0] x, input logic [31:0] p1,
                      input logic [31:0] p2, input bit abort, input bit wiggle);
    int wa;
    int d1;
    int d2;
    @(negedge clk);
    data_adc   = x;
    par_delay1 = p1;
    par_delay2 = p2;
    data_rdy   = 1'b1;
    model_accept(x, p1, p2, wa, d1, d2);
    @(negedge clk);  // WRITE
    data_rdy = 1'b0;
    if (wiggle) begin
      par_delay1 = $urandom;
      par_delay2 = $urandom;
      data_adc   = DW'($urandom);
      enable     = 1'($urandom_range(0, 1));
    end
    check("we_a", 32'(ram_bus.we_a), 32'(1));
    check("adr_a", 32'(ram_bus.adr_a), 32'(wa));
    check("dat_a", 32'(ram_bus.dat_a), 32'(x));
    check("tap_d1", 32'(tap_d1), 32'(d1));
    @(negedge clk);  // RD1
    check("adr_b_tap1", 32'(ram_bus.adr_b), 32'((wa - d1 + DEPTH) % DEPTH));
    check("tap_d2", 32'(tap_d2), 32'(d2));
    @(negedge clk);  // RD2
    check("adr_b_tap2", 32'(ram_bus.adr_b), 32'((wa - d2 + DEPTH) % DEPTH));
    if (abort) begin
      reset = 1'b1;
      exp_q.delete();
      hist.delete();
      last = '0;
      @(negedge clk);
      check("abort_outputs", 32'({realt, delay1, delay2}), 32'(0));
      check("abort_flags", 32'({out_valid, busy, overrun}), 32'(0));
      check("abort_adr", 32'({ram_bus.adr_a, ram_bus.adr_b}), 32'(0));
      reset = 1'b0;
    end else begin
      @(negedge clk);  // CAP
      check("busy_cap", 32'(busy), 32'(1));
      @(negedge clk);  // result visible
      check("busy_done", 32'(busy), 32'(0));
    end
    enable = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    do_reset();

    // Single sample, zero delays: taps read back the sample just written.
    send(8'h5A, 32'd0, 32'd0, 1'b0, 1'b0);

    // Short delays from an empty delay line: warm-up masking.
    do_reset();
    for (int i = 1; i <= 8; i++) send(DW'(i), 32'd3, 32'd5, 1'b0, 1'b0);

    // Second edge two cycles after the first is dropped and flagged.
    begin
      int wa;
      int d1;
      int d2;
      @(negedge clk);
      data_adc = 8'h33; par_delay1 = 32'd2; par_delay2 = 32'd4; data_rdy = 1'b1;
      model_accept(8'h33, 32'd2, 32'd4, wa, d1, d2);
      @(negedge clk);
      data_rdy = 1'b0;
      @(negedge clk);
      data_rdy = 1'b1; data_adc = 8'hEE;
      @(negedge clk);
      check("overrun_pulse", 32'(overrun), 32'(1));
      data_rdy = 1'b0;
      exp_ovr++;
      @(negedge clk);
      check("overrun_single", 32'(overrun), 32'(0));
      repeat (2) @(negedge clk);
    end
    check("writes_after_overrun", 32'(wr_seen), 32'(exp_writes));

    // Edges with enable low are ignored.
    enable = 1'b0;
    @(negedge clk); data_rdy = 1'b1;
    @(negedge clk); data_rdy = 1'b0;
    check("enable_low_idle", 32'(busy), 32'(0));
    repeat (3) @(negedge clk);
    enable = 1'b1;
    check("enable_low_writes", 32'(wr_seen), 32'(exp_writes));

    // Reset during RD2, then a fresh sample lands at address 0 with masked taps.
    send(8'h77, 32'd1, 32'd1, 1'b1, 1'b0);
    send(8'h21, 32'd3, 32'd3, 1'b0, 1'b0);

    // Random samples, delays and idle gaps; params and enable disturbed mid-flight.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] p2;
      p2 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
      send(DW'($urandom), 32'($urandom_range(0, 12)), p2, 1'b0, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Full-length run: huge tap-1 delay clamps to DEPTH-1, tap 2 at 10 back,
    // write address wraps past DEPTH-1.
    do_reset();
    for (int i = 0; i < DEPTH + 8; i++) begin
      send(DW'($urandom), 32'hFFFF_FFFF, 32'd10, 1'b0, 1'b0);
    end

    repeat (4) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'(0));
    check("write_count", 32'(wr_seen), 32'(exp_writes));
    check("overrun_count", 32'(ovr_seen), 32'(exp_ovr));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
